// File: rtl/grey_init_loader.sv
// Serial preload controller for the 12-digit Johnson-coded decimal counter.
// Receives INIT MSB-first one bit per cycle, checks each digit, then strobes INIT.
module grey_init_loader #(
    parameter int unsigned NDIG    = 12,
    parameter int unsigned DW      = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 SDI,
    input  logic                 SVALID,
    output logic [NDIG*DW-1:0]   INIT,
    output logic                 INIT_STB,
    output logic                 CNT_HOLD,
    output logic                 BUSY,
    output logic                 ERR,
    output logic [3:0]           DIG_IDX
);

    localparam int unsigned W  = NDIG * DW;
    localparam int unsigned IW = 8;
    localparam int unsigned BW = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          state;
    logic [W-2:0]    shadow;
    logic [BW-1:0]   bit_pos;
    logic [IW-1:0]   idle_cnt;
    logic [W-1:0]    shift_c;

    // Shadow with the current SDI appended; its low DW bits are the digit being completed.
    assign shift_c = {shadow, SDI};

    function automatic logic digit_legal(input logic [4:0] code);
        case (code)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: digit_legal = 1'b1;
            default:                                          digit_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            shadow   <= '0;
            bit_pos  <= '0;
            idle_cnt <= '0;
            INIT     <= '0;
            INIT_STB <= 1'b0;
            CNT_HOLD <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
            DIG_IDX  <= '0;
        end else begin
            INIT_STB <= 1'b0;
            // START begins a fresh frame from any state; a COMMIT in flight still completes.
            if (START) begin
                state    <= S_SHIFT;
                shadow   <= '0;
                bit_pos  <= '0;
                idle_cnt <= '0;
                DIG_IDX  <= '0;
                ERR      <= 1'b0;
                BUSY     <= 1'b1;
                CNT_HOLD <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        BUSY     <= 1'b0;
                        CNT_HOLD <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (SVALID) begin
                            shadow   <= shift_c[W-2:0];
                            idle_cnt <= '0;
                            if (bit_pos == BW'(DW - 1)) begin
                                if (!digit_legal(shift_c[DW-1:0])) begin
                                    state    <= S_IDLE;
                                    ERR      <= 1'b1;
                                    BUSY     <= 1'b0;
                                    CNT_HOLD <= 1'b0;
                                end else if (DIG_IDX == 4'(NDIG - 1)) begin
                                    state    <= S_COMMIT;
                                    INIT     <= shift_c;
                                    INIT_STB <= 1'b1;
                                end else begin
                                    DIG_IDX <= DIG_IDX + 4'd1;
                                    bit_pos <= '0;
                                end
                            end else begin
                                bit_pos <= bit_pos + BW'(1);
                            end
                        end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                            state    <= S_IDLE;
                            ERR      <= 1'b1;
                            BUSY     <= 1'b0;
                            CNT_HOLD <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    S_COMMIT: begin
                        state    <= S_IDLE;
                        BUSY     <= 1'b0;
                        CNT_HOLD <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grey_init_loader.sv
// Bench for grey_init_loader: directed scenarios plus random traffic checked every
// cycle against a queue-based frame model.
module tb_grey_init_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SDI = 1'b0;
    logic        SVALID = 1'b0;
    logic [59:0] INIT;
    logic        INIT_STB;
    logic        CNT_HOLD;
    logic        BUSY;
    logic        ERR;
    logic [3:0]  DIG_IDX;

    grey_init_loader dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .SDI      (SDI),
        .SVALID   (SVALID),
        .INIT     (INIT),
        .INIT_STB (INIT_STB),
        .CNT_HOLD (CNT_HOLD),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .DIG_IDX  (DIG_IDX)
    );

    always #5 CLK = ~CLK;

    localparam logic [59:0] K_FULL = 60'h08CEFFFB9880023;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] jtab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                              5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

    // Frame-level model: accepted bits in a queue, plus a few flags.
    bit          m_active = 1'b0;
    bit          m_commit = 1'b0;
    bit          m_err    = 1'b0;
    int          m_idle   = 0;
    logic [59:0] m_init   = '0;
    bit          m_bits [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_code(input logic [4:0] c);
        for (int i = 0; i < 10; i++) if (jtab[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic st, input logic d, input logic v, input logic r);
        logic [4:0] grp;
        int n;
        if (r) begin
            m_active = 0; m_commit = 0; m_err = 0; m_idle = 0; m_init = '0;
            m_bits.delete();
        end else if (st) begin
            m_active = 1; m_commit = 0; m_err = 0; m_idle = 0;
            m_bits.delete();
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_active) begin
            if (v) begin
                m_bits.push_back(d);
                m_idle = 0;
                n = m_bits.size();
                if (n % 5 == 0) begin
                    for (int k = 0; k < 5; k++) grp[4-k] = m_bits[n-5+k];
                    if (!is_code(grp)) begin
                        m_active = 0; m_err = 1;
                    end else if (n == 60) begin
                        for (int k = 0; k < 60; k++) m_init[59-k] = m_bits[k];
                        m_active = 0; m_commit = 1;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == 255) begin
                    m_active = 0; m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("init", 64'(INIT), 64'(m_init));
        check("stb",  64'(INIT_STB), 64'(m_commit));
        check("hold", 64'(CNT_HOLD), 64'(m_active | m_commit));
        check("busy", 64'(BUSY), 64'(m_active | m_commit));
        check("err",  64'(ERR), 64'(m_err));
        if (m_active) check("dig_idx", 64'(DIG_IDX), 64'(m_bits.size() / 5));
    endtask

    task automatic tick(input logic st, input logic d, input logic v, input logic r);
        @(negedge CLK);
        START = st; SDI = d; SVALID = v; RST = r;
        @(posedge CLK);
        model_step(st, d, v, r);
        #1 compare_all();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
    endtask

    // Sends bits [from, from+n) of v MSB-first, optionally with SVALID gaps.
    task automatic send_bits(input logic [59:0] v, input int from, input int n,
                             input int gap_every, input int gap_len);
        for (int i = from; i < from + n; i++) begin
            tick(1'b0, v[59-i], 1'b1, 1'b0);
            if (gap_every > 0 && ((i + 1) % gap_every) == 0 && i != 59) idle_ticks(gap_len);
        end
    endtask

    function automatic logic [59:0] rand_frame(input bit bad);
        logic [59:0] v;
        logic [4:0]  c;
        int          bad_k;
        bad_k = bad ? int'($urandom_range(11)) : -1;
        for (int k = 0; k < 12; k++) begin
            c = jtab[$urandom_range(9)];
            if (k == bad_k) begin
                c = 5'($urandom);
                while (is_code(c)) c = 5'($urandom);
            end
            v[59-5*k -: 5] = c;
        end
        return v;
    endfunction

    logic [59:0] va, vb, plan;
    int          pos;

    initial begin
        // Reset held two cycles
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_init", 64'(INIT), 64'd0);
        check("rst_dig", 64'(DIG_IDX), 64'd0);
        idle_ticks(2);

        // Contiguous frame 123456789012
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(K_FULL, 0, 60, 0, 0);
        check("full_stb", 64'(INIT_STB), 64'd1);
        check("full_init", 64'(INIT), 64'(K_FULL));
        idle_ticks(3);

        // Gapped frame, same value
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(K_FULL, 0, 60, 7, 3);
        check("gap_stb", 64'(INIT_STB), 64'd1);
        check("gap_init", 64'(INIT), 64'(K_FULL));
        idle_ticks(2);

        // Illegal digit 3 (00101)
        va = K_FULL;
        va[44:40] = 5'b00101;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(va, 0, 20, 0, 0);
        check("bad_err", 64'(ERR), 64'd1);
        check("bad_hold", 64'(CNT_HOLD), 64'd0);
        check("bad_init", 64'(INIT), 64'(K_FULL));
        send_bits(va, 20, 40, 0, 0);
        check("bad_nostb", 64'(INIT_STB), 64'd0);

        // Timeout: idle counter clears on each bit; 254 idle cycles survive, 255 abort
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("to_err_clr", 64'(ERR), 64'd0);
        send_bits(K_FULL, 0, 10, 0, 0);
        idle_ticks(200);
        send_bits(K_FULL, 10, 7, 0, 0);
        idle_ticks(254);
        check("to_254_busy", 64'(BUSY), 64'd1);
        idle_ticks(1);
        check("to_err", 64'(ERR), 64'd1);
        check("to_busy", 64'(BUSY), 64'd0);
        idle_ticks(2);

        // Restart after timeout commits a fresh frame
        vb = rand_frame(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("rs_err_clr", 64'(ERR), 64'd0);
        send_bits(vb, 0, 60, 0, 0);
        check("rs_init", 64'(INIT), 64'(vb));

        // START on the COMMIT cycle goes straight to SHIFT after the strobe
        va = rand_frame(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("cs_busy", 64'(BUSY), 64'd1);
        check("cs_stb", 64'(INIT_STB), 64'd0);
        send_bits(va, 0, 60, 0, 0);
        check("cs_init", 64'(INIT), 64'(va));
        idle_ticks(1);

        // Mid-frame restart after 30 bits
        vb = rand_frame(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(va ^ 60'hFFFFFFFFFFFFFFF, 0, 30, 0, 0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("mr_dig", 64'(DIG_IDX), 64'd0);
        send_bits(vb, 0, 60, 0, 0);
        check("mr_init", 64'(INIT), 64'(vb));
        idle_ticks(1);

        // Reset after 40 bits
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(rand_frame(1'b0), 0, 40, 0, 0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("rm_init", 64'(INIT), 64'd0);
        check("rm_busy", 64'(BUSY), 64'd0);
        idle_ticks(2);

        // Random traffic: SDI follows a planned frame, some frames carry an illegal digit
        plan = rand_frame(1'b0);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            logic st, v, r, d;
            int   p;
            p  = int'($urandom_range(999));
            r  = (p < 2);
            if (m_active)      st = (p >= 2 && p < 8);
            else if (m_commit) st = (p >= 2 && p < 300);
            else               st = (p >= 2 && p < 350);
            v   = ($urandom_range(99) < 75);
            pos = m_bits.size();
            d   = (m_active && pos < 60) ? plan[59-pos] : 1'($urandom);
            if (st) plan = rand_frame($urandom_range(99) < 20);
            tick(st, d, v, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
